// File: rtl/multi_mode_shift_reg_pkg.sv
// Shared constants and helpers for the multi-mode shift register family.
// Mode and direction encodings match the external mode/dir port values.
package msr_pkg;

    localparam logic [1:0] MODE_SHIFT   = 2'd0;
    localparam logic [1:0] MODE_RING    = 2'd1;
    localparam logic [1:0] MODE_JOHNSON = 2'd2;
    localparam logic [1:0] MODE_COUNT   = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Steps per pattern period. COUNT ignores this: it signals on the wrap instead.
    function automatic int period(input logic [1:0] mode, input int width);
        return (mode == MODE_JOHNSON) ? 2 * width : width;
    endfunction

endpackage

// File: rtl/multi_mode_shift_reg_period_tracker.sv
// Counts enabled steps within the current pattern period and produces the
// registered one-cycle tc pulse; restarts the period whenever the mode changes.
module msr_period_tracker
    import msr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       load,
    input  logic [1:0] mode,
    input  logic       count_wrap,
    output logic       tc
);

    localparam int CNT_W = $clog2(2 * WIDTH);

    logic [CNT_W-1:0] step_cnt_reg;
    logic [CNT_W-1:0] step_cnt_next;
    logic [CNT_W-1:0] last_cnt;
    logic [1:0]       mode_q_reg;
    logic             tc_reg;
    logic             tc_next;

    assign last_cnt = CNT_W'(period(mode, WIDTH) - 1);

    always_comb begin
        step_cnt_next = step_cnt_reg;
        tc_next       = 1'b0;
        if (load) begin
            step_cnt_next = '0;
        end else if (mode != mode_q_reg) begin
            // The switching step is the first step of the new mode's period.
            step_cnt_next = (step && mode != MODE_COUNT) ? CNT_W'(1) : '0;
        end else if (step) begin
            if (mode == MODE_COUNT) begin
                step_cnt_next = '0;
                tc_next       = count_wrap;
            end else if (step_cnt_reg == last_cnt) begin
                step_cnt_next = '0;
                tc_next       = 1'b1;
            end else begin
                step_cnt_next = step_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        mode_q_reg <= mode;
        if (rst) begin
            step_cnt_reg <= '0;
            tc_reg       <= 1'b0;
        end else begin
            step_cnt_reg <= step_cnt_next;
            tc_reg       <= tc_next;
        end
    end

    assign tc = tc_reg;

endmodule

// File: rtl/multi_mode_shift_reg.sv
// WIDTH-bit pattern generator: serial shift, ring, Johnson or up/down count,
// with parallel load, enable, serial output and a period-complete pulse.
module multi_mode_shift_reg
    import msr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tc
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] stepped;
    logic             fill_l;
    logic             fill_r;
    logic             count_wrap;

    // Neighbour wiring for the shift paths; only the entry bit depends on mode.
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_shl
            assign shl[gi] = q_reg[gi-1];
        end
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
            assign shr[gi] = q_reg[gi+1];
        end
    endgenerate

    assign shl[0]       = fill_l;
    assign shr[WIDTH-1] = fill_r;

    always_comb begin
        fill_l = sin;
        fill_r = sin;
        case (mode)
            MODE_RING: begin
                fill_l = q_reg[WIDTH-1];
                fill_r = q_reg[0];
            end
            MODE_JOHNSON: begin
                fill_l = ~q_reg[WIDTH-1];
                fill_r = ~q_reg[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        stepped = (dir == DIR_RIGHT) ? shr : shl;
        if (mode == MODE_COUNT) begin
            stepped = (dir == DIR_RIGHT) ? q_reg - WIDTH'(1) : q_reg + WIDTH'(1);
        end
    end

    assign count_wrap = (mode == MODE_COUNT) &&
                        ((dir == DIR_RIGHT) ? (q_reg == '0) : (&q_reg));

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = d;
        end else if (en) begin
            q_next = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= INIT;
        end else begin
            q_reg <= q_next;
        end
    end

    msr_period_tracker #(
        .WIDTH(WIDTH)
    ) u_period_tracker (
        .clk       (clk),
        .rst       (rst),
        .step      (en),
        .load      (load),
        .mode      (mode),
        .count_wrap(count_wrap),
        .tc        (tc)
    );

    assign q    = q_reg;
    assign sout = (dir == DIR_RIGHT) ? q_reg[0] : q_reg[WIDTH-1];

endmodule
